// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU decode stage: 5-bit ALU op codes, handshake
// FSM states and the multi-cycle latency counter width.
`timescale 1ns/1ps
package alu_ctrl_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = 6;

  localparam logic [CODE_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [CODE_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [CODE_W-1:0] ALU_AND  = 5'b00010;
  localparam logic [CODE_W-1:0] ALU_OR   = 5'b00011;
  localparam logic [CODE_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [CODE_W-1:0] ALU_SLT  = 5'b00101;
  localparam logic [CODE_W-1:0] ALU_SLTU = 5'b00110;
  localparam logic [CODE_W-1:0] ALU_SLL  = 5'b00111;
  localparam logic [CODE_W-1:0] ALU_SRL  = 5'b01000;
  localparam logic [CODE_W-1:0] ALU_SRA  = 5'b01001;

  // M-extension codes are this prefix concatenated with funct3
  localparam logic [1:0] ALU_M_PFX = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_FULL = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from opcode/funct fields and the main-decoder
// class, flagging unsupported encodings and multi-cycle M-extension ops.
`timescale 1ns/1ps
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MEXT = 1
) (
  input  logic [6:0]        op_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [1:0]        alu_op_i,
  output logic [CODE_W-1:0] code_o,
  output logic              illegal_o,
  output logic              is_mul_o,
  output logic              is_div_o
);

  // Only op[5] (register-register form) matters for ALU control
  logic op_unused;
  assign op_unused = ^{op_i[6], op_i[4:0]};

  always_comb begin
    code_o    = ALU_ADD;
    illegal_o = 1'b0;
    is_mul_o  = 1'b0;
    is_div_o  = 1'b0;
    case (alu_op_i)
      2'b00: code_o = ALU_ADD;
      2'b01: code_o = ALU_SUB;
      2'b11: illegal_o = 1'b1;
      default: begin
        if (op_i[5] && (funct7_i == 7'b0000001)) begin
          if (MEXT != 0) begin
            code_o   = {ALU_M_PFX, funct3_i};
            is_mul_o = ~funct3_i[2];
            is_div_o = funct3_i[2];
          end else begin
            illegal_o = 1'b1;
          end
        end else begin
          case (funct3_i)
            3'b000:  code_o = (op_i[5] && funct7_i[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  code_o = ALU_SLL;
            3'b010:  code_o = ALU_SLT;
            3'b011:  code_o = ALU_SLTU;
            3'b100:  code_o = ALU_XOR;
            3'b101:  code_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
            3'b110:  code_o = ALU_OR;
            default: code_o = ALU_AND;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode pipeline stage with valid/ready handshake; MUL/DIV ops
// are held in WAIT for their execute latency before the result is presented.
`timescale 1ns/1ps
module alu_decode_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MEXT    = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [1:0]  ALUOp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  ALUControl,
  output logic        illegal,
  output logic        busy
);

  // Counter counts down to zero, so it loads LAT-2 to land in FULL after LAT cycles
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'((DIV_LAT > 1) ? (DIV_LAT - 2) : 0);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CODE_W-1:0]   ctrl_q;
  logic                illegal_q;

  logic [CODE_W-1:0]   dec_code;
  logic                dec_illegal;
  logic                dec_mul;
  logic                dec_div;
  logic                accept;
  logic                multi_d;
  logic [CNT_W-1:0]    cnt_d;

  alu_ctrl_decode #(
    .MEXT (MEXT)
  ) u_decode (
    .op_i      (op),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_op_i  (ALUOp),
    .code_o    (dec_code),
    .illegal_o (dec_illegal),
    .is_mul_o  (dec_mul),
    .is_div_o  (dec_div)
  );

  assign in_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_FULL) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    multi_d = (dec_mul && (MUL_LAT > 1)) || (dec_div && (DIV_LAT > 1));
    cnt_d   = dec_div ? DIV_LD : MUL_LD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= ALU_ADD;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      ctrl_q    <= dec_code;
      illegal_q <= dec_illegal;
      if (multi_d) begin
        state_q <= ST_WAIT;
        cnt_q   <= cnt_d;
      end else begin
        state_q <= ST_FULL;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_FULL;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = (state_q == ST_FULL);
  assign busy       = (state_q == ST_WAIT);
  assign ALUControl = ctrl_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized and directed bench for alu_decode_stage against a timestamp-based
// transaction model of decode and execute latency.
`timescale 1ns/1ps
module tb_alu_decode_stage;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] alu_op;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] alu_ctrl;
  logic       illegal;
  logic       busy;

  logic       in_valid2;
  logic       in_ready2;
  logic       out_valid2;
  logic [4:0] alu_ctrl2;
  logic       illegal2;
  logic       busy2;

  int n_total = 0;
  int n_bad   = 0;

  // Transaction model: one held result that becomes visible at cycle m_avail
  int         cyc = 0;
  bit         m_have = 1'b0;
  int         m_avail = 0;
  logic [4:0] m_code = '0;
  logic       m_ill = 1'b0;

  always #5 clk = ~clk;

  alu_decode_stage #(.MEXT(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct3(funct3), .funct7(funct7), .ALUOp(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .ALUControl(alu_ctrl),
    .illegal(illegal), .busy(busy)
  );

  alu_decode_stage #(.MEXT(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut_rv (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .funct3(funct3), .funct7(funct7), .ALUOp(alu_op),
    .out_valid(out_valid2), .out_ready(1'b1), .ALUControl(alu_ctrl2),
    .illegal(illegal2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns {illegal, code} straight from the instruction-field rules
  function automatic logic [5:0] ref_decode(input logic [6:0] o, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [1:0] aop,
                                            input bit mext);
    if (aop == 2'd0) return {1'b0, 5'd0};
    if (aop == 2'd1) return {1'b0, 5'd1};
    if (aop == 2'd3) return {1'b1, 5'd0};
    if (o[5] && f7 == 7'd1) return mext ? {1'b0, 2'b10, f3} : {1'b1, 5'd0};
    case (f3)
      3'd0:    return {1'b0, (o[5] && f7[5]) ? 5'd1 : 5'd0};
      3'd1:    return {1'b0, 5'd7};
      3'd2:    return {1'b0, 5'd5};
      3'd3:    return {1'b0, 5'd6};
      3'd4:    return {1'b0, 5'd4};
      3'd5:    return {1'b0, f7[5] ? 5'd9 : 5'd8};
      3'd6:    return {1'b0, 5'd3};
      default: return {1'b0, 5'd2};
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] code);
    if (code[4]) return code[2] ? int'(DIV_LAT) : int'(MUL_LAT);
    return 1;
  endfunction

  // Called at a negedge: checks outputs, drives inputs, advances one clock, ends at next negedge
  task automatic drive_cycle(input logic iv, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [1:0] aop,
                             input logic fl, input logic ordy);
    logic       exp_ov;
    logic       exp_rdy;
    logic       acc;
    logic [5:0] d;
    exp_ov = m_have && (cyc >= m_avail);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("busy", 32'(busy), 32'(m_have && (cyc < m_avail)));
    if (exp_ov) begin
      check("ALUControl", 32'(alu_ctrl), 32'(m_code));
      check("illegal", 32'(illegal), 32'(m_ill));
    end
    in_valid  = iv;
    op        = o;
    funct3    = f3;
    funct7    = f7;
    alu_op    = aop;
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_rdy = !fl && (!m_have || (exp_ov && ordy));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    d   = ref_decode(o, f3, f7, aop, 1'b1);
    @(posedge clk);
    cyc++;
    if (fl) begin
      m_have = 1'b0;
    end else if (acc) begin
      m_have  = 1'b1;
      m_code  = d[4:0];
      m_ill   = d[5];
      m_avail = cyc + lat_of(d[4:0]) - 1;
    end else if (exp_ov && ordy) begin
      m_have = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 7'h33, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1);
  endtask

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
    op = '0; funct3 = '0; funct7 = '0; alu_op = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ALUControl", 32'(alu_ctrl), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // R-type sub
    drive_cycle(1'b1, OP_R, 3'b000, 7'b0100000, 2'b10, 1'b0, 1'b1);
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_code", 32'(alu_ctrl), 32'h01);
    check("sub_illegal", 32'(illegal), 32'd0);
    idle_cycles(1);

    // Back-to-back sra then srl
    drive_cycle(1'b1, OP_R, 3'b101, 7'b0100000, 2'b10, 1'b0, 1'b1);
    check("sra_code", 32'(alu_ctrl), 32'h09);
    drive_cycle(1'b1, OP_R, 3'b101, 7'b0000000, 2'b10, 1'b0, 1'b1);
    check("srl_code", 32'(alu_ctrl), 32'h08);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    idle_cycles(1);

    // DIV: 32 busy cycles then result; MEXT=0 instance flags the same encoding illegal
    drive_cycle(1'b1, OP_R, 3'b100, 7'b0000001, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      check("div_busy", 32'(busy), 32'd1);
      drive_cycle(1'b0, OP_R, 3'b100, 7'b0000001, 2'b10, 1'b0, 1'b1);
    end
    check("div_valid", 32'(out_valid), 32'd1);
    check("div_code", 32'(alu_ctrl), 32'h14);
    idle_cycles(1);
    in_valid2 = 1'b1;
    drive_cycle(1'b0, OP_R, 3'b100, 7'b0000001, 2'b10, 1'b0, 1'b1);
    in_valid2 = 1'b0;
    check("rv_valid", 32'(out_valid2), 32'd1);
    check("rv_code", 32'(alu_ctrl2), 32'h00);
    check("rv_illegal", 32'(illegal2), 32'd1);
    check("rv_busy", 32'(busy2), 32'd0);
    idle_cycles(1);

    // Backpressure then no-bubble handoff
    drive_cycle(1'b1, OP_R, 3'b110, 7'd0, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, OP_R, 3'b111, 7'd0, 2'b10, 1'b0, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_code", 32'(alu_ctrl), 32'h03);
    end
    drive_cycle(1'b1, OP_R, 3'b100, 7'd0, 2'b10, 1'b0, 1'b1);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_code", 32'(alu_ctrl), 32'h04);
    idle_cycles(1);

    // Flush in WAIT with a concurrent request
    drive_cycle(1'b1, OP_R, 3'b110, 7'b0000001, 2'b10, 1'b0, 1'b1);
    idle_cycles(9);
    drive_cycle(1'b1, OP_R, 3'b000, 7'd0, 2'b10, 1'b1, 1'b1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    idle_cycles(40);

    // Reset pulse mid-WAIT
    drive_cycle(1'b1, OP_R, 3'b101, 7'b0000001, 2'b10, 1'b0, 1'b1);
    idle_cycles(5);
    reset = 1'b1;
    #1;
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_valid", 32'(out_valid), 32'd0);
    check("rstw_code", 32'(alu_ctrl), 32'd0);
    check("rstw_illegal", 32'(illegal), 32'd0);
    m_have = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_in_ready", 32'(in_ready), 32'd1);
    idle_cycles(40);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] ro;
      logic [6:0] rf7;
      int         pick;
      pick = $urandom_range(0, 3);
      ro   = (pick == 0) ? OP_R : (pick == 1) ? OP_I : (pick == 2) ? OP_R : 7'($urandom);
      pick = $urandom_range(0, 3);
      rf7  = (pick == 0) ? 7'd0 : (pick == 1) ? 7'h20 : (pick == 2) ? 7'h01 : 7'($urandom);
      drive_cycle(1'($urandom_range(0, 9) < 7), ro, 3'($urandom), rf7, 2'($urandom),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
    end
    idle_cycles(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
